// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the 8N1 UART receive path.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Prescaler divide ratio, floored.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line input and received-byte outputs of the receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    import uart_pkg::*;

    logic                      RX;
    logic [UART_DATA_BITS-1:0] DATA;
    logic                      VALID;
    logic                      FRAME_ERR;
    logic                      BUSY;

    modport master (output RX, input DATA, input VALID, input FRAME_ERR, input BUSY);
    modport slave  (input RX, output DATA, output VALID, output FRAME_ERR, output BUSY);

endinterface
`default_nettype wire

// File: rtl/uart_rx_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Clock-enable prescaler, one tick every DIV cycles; clr holds phase.
//  Revision    : 1.0  initial release
// ============================================================================
module baud_tick_gen #(
    parameter int DIV = 325
) (
    input  logic CLK_50M,
    input  logic RST_N,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == c_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, 16x oversampled, mid-bit sampling.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    uart_rx_if.slave   bus
);

    localparam int               DIV        = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int               SUB_W      = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0] c_SUB_HALF = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] c_SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       c_LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta_q, rx_s_q;
    uart_state_e               state_q, state_d;
    logic [SUB_W-1:0]          sub_q;
    logic [2:0]                bit_q;
    logic [UART_DATA_BITS-1:0] shift_q, data_q;
    logic                      valid_q, ferr_q;

    logic w_idle, w_tick, w_mid_start, w_bit_end, w_busy;

    // Synchronizer flops reset to the idle line level.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign w_idle = (state_q == ST_IDLE);

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .CLK_50M (CLK_50M),
        .RST_N   (RST_N),
        .clr     (w_idle),
        .tick    (w_tick)
    );

    assign w_mid_start = (state_q == ST_START) && w_tick && (sub_q == c_SUB_HALF);
    assign w_bit_end   = w_tick && (sub_q == c_SUB_LAST);

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s_q) state_d = ST_START;
            ST_START: if (w_mid_start) state_d = rx_s_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_bit_end && (bit_q == c_LAST_BIT)) state_d = ST_STOP;
            ST_STOP:  if (w_bit_end) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sub_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (w_idle || w_mid_start) begin
                sub_q <= '0;
            end else if (w_tick) begin
                sub_q <= (sub_q == c_SUB_LAST) ? '0 : sub_q + 1'b1;
            end
            if (w_idle) begin
                bit_q <= '0;
            end else if ((state_q == ST_DATA) && w_bit_end) begin
                bit_q   <= bit_q + 1'b1;
                shift_q <= {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
            end
            if ((state_q == ST_STOP) && w_bit_end) begin
                if (rx_s_q) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ferr_q  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_busy = (state_q != ST_IDLE);
    end

    assign bus.DATA      = data_q;
    assign bus.VALID     = valid_q;
    assign bus.FRAME_ERR = ferr_q;
    assign bus.BUSY      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Randomized and directed frames against an event-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 10000;
    localparam int OS     = 16;
    localparam int DIV    = CLK_HZ / (BAUD * OS);
    localparam int BIT    = OS * DIV;
    localparam int LAT    = (OS / 2 + 9 * OS) * DIV + 3;

    typedef struct {
        int         kind;   // 1 = VALID, 2 = FRAME_ERR
        int         cyc;
        logic [7:0] data;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    ev_t  got_q[$];
    ev_t  exp_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   viol    = 0;
    int   busy_lo = 0;
    bit   win     = 1'b0;
    bit   prev_pulse = 1'b0;
    logic [7:0] last_good;

    uart_rx_if bus();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .CLK_50M (clk),
        .RST_N   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (bus.VALID === 1'b1) begin
            e.kind = 1; e.cyc = cyc; e.data = bus.DATA;
            got_q.push_back(e);
        end
        if (bus.FRAME_ERR === 1'b1) begin
            e.kind = 2; e.cyc = cyc; e.data = bus.DATA;
            got_q.push_back(e);
        end
        if (bus.VALID && bus.FRAME_ERR) viol <= viol + 1;
        else if ((bus.VALID || bus.FRAME_ERR) && prev_pulse) viol <= viol + 1;
        prev_pulse <= bus.VALID || bus.FRAME_ERR;
        if (win && bus.BUSY !== 1'b1) busy_lo <= busy_lo + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame and records what a correct receiver must report for it.
    task automatic send(input logic [7:0] b, input bit stop_ok, input int p);
        ev_t e;
        e.kind = stop_ok ? 1 : 2;
        e.cyc  = cyc + LAT;
        e.data = stop_ok ? b : last_good;
        if (stop_ok) last_good = b;
        exp_q.push_back(e);
        bus.RX = 1'b0;
        hold(p);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            hold(p);
        end
        bus.RX = stop_ok;
        hold(p);
    endtask

    task automatic check_events(input string tag);
        int d;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            d = got_q[i].cyc - exp_q[i].cyc;
            chk({tag, "_kind"}, got_q[i].kind, exp_q[i].kind);
            chk({tag, "_data"}, got_q[i].data, exp_q[i].data);
            chk({tag, "_lat"}, (d >= -1 && d <= 1) ? LAT : LAT + d, LAT);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         p;
        int         g;
        bit         ok;

        bus.RX    = 1'b1;
        last_good = 8'h00;
        hold(5);
        chk("rst_data",  bus.DATA, 8'h00);
        chk("rst_valid", bus.VALID, 1'b0);
        chk("rst_ferr",  bus.FRAME_ERR, 1'b0);
        chk("rst_busy",  bus.BUSY, 1'b0);
        rst_n = 1'b1;
        hold(5);
        chk("idle_busy", bus.BUSY, 1'b0);

        // Single byte, BUSY watched across the frame
        fork
            send(8'hA5, 1'b1, BIT);
            begin
                hold(4);
                win = 1'b1;
                hold(LAT - 8);
                win = 1'b0;
            end
        join
        hold(20);
        check_events("a5");
        chk("a5_data", bus.DATA, 8'hA5);
        chk("a5_busy", busy_lo, 0);

        // Back-to-back frames with no idle gap
        send(8'h00, 1'b1, BIT);
        send(8'hFF, 1'b1, BIT);
        hold(20);
        check_events("b2b");

        // Glitch shorter than half a bit
        bus.RX = 1'b0;
        hold(20);
        chk("fs_busy_hi", bus.BUSY, 1'b1);
        hold(20);
        bus.RX = 1'b1;
        hold(200);
        chk("fs_busy", bus.BUSY, 1'b0);
        check_events("fs");

        // Low stop bit followed by a held-low line
        send(8'h3C, 1'b0, BIT);
        hold(3 * BIT);
        chk("fe_busy_hold", bus.BUSY, 1'b1);
        bus.RX = 1'b1;
        hold(10);
        chk("fe_busy_rel", bus.BUSY, 1'b0);
        check_events("fe");
        chk("fe_data", bus.DATA, 8'hFF);

        // Reset in the middle of bit 4
        fork
            send(8'hC3, 1'b1, BIT);
            begin
                hold(BIT * 5 + BIT / 2);
                rst_n = 1'b0;
                hold(5);
                chk("mid_rst_data", bus.DATA, 8'h00);
                chk("mid_rst_busy", bus.BUSY, 1'b0);
            end
        join
        hold(5);
        rst_n = 1'b1;
        hold(20);
        chk("abort_none", got_q.size(), 0);
        got_q.delete();
        exp_q.delete();
        last_good = 8'h00;
        chk("abort_data", bus.DATA, 8'h00);
        send(8'h5A, 1'b1, BIT);
        hold(20);
        check_events("post_rst");

        // Bit-rate offset of +/-2 percent
        send(8'h81, 1'b1, BIT * 102 / 100);
        hold(5);
        send(8'h81, 1'b1, BIT * 98 / 100);
        hold(20);
        check_events("rate");

        // Random bytes, rates, gaps and stop-bit errors
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom);
            p  = int'($urandom_range(BIT * 102 / 100, BIT * 98 / 100));
            ok = ($urandom_range(3, 0) != 0);
            send(b, ok, p);
            if (!ok) begin
                bus.RX = 1'b1;
                hold(int'($urandom_range(60, 20)));
            end else begin
                g = int'($urandom_range(40, 0));
                if (g > 0) hold(g);
            end
        end
        hold(20);
        check_events("rnd");
        chk("rnd_data", bus.DATA, last_good);

        chk("pulse_excl", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
